// File: rtl/fixed_pkg.sv
// fixed_pkg: shared Q5.26 fixed-point constants, divider state encoding and abs helper
package fixed_pkg;
  localparam int WIDTH = 32;
  localparam int FRAC = 26;
  localparam int N = WIDTH + FRAC;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [WIDTH-1:0] Q_MAX_POS = 32'h7FFF_FFFF;
  localparam logic [WIDTH-1:0] Q_MAX_NEG = 32'h8000_0000;
  localparam logic [WIDTH-1:0] ONE = 32'h0400_0000;
  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1)
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? ~(x - WIDTH'(1)) : x;
  endfunction
endpackage

// File: rtl/fixed_divstep.sv
// fixed_divstep: one combinational restoring-division step
module fixed_divstep
  import fixed_pkg::*;
(
  input  logic [WIDTH:0]   r,
  input  logic             d_bit,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] r_sh;
  always_comb begin
    r_sh = {r, d_bit};
    q_bit = r_sh >= {2'b00, b_mag};
    r_next = q_bit ? (WIDTH+1)'(r_sh - {2'b00, b_mag}) : (WIDTH+1)'(r_sh);
  end
endmodule

// File: rtl/divfixed_seq.sv
// divfixed_seq: sequential signed Q5.26 restoring divider with saturation and divide-by-zero flag
module divfixed_seq
  import fixed_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             ovf,
  output logic             dbz,
  output logic             busy
);
  state_t state;
  logic [N-1:0] d, qm;
  logic [WIDTH:0] r, r_next;
  logic [WIDTH-1:0] b_mag, q_res;
  logic sgn, a_neg, zero_b, q_bit, ovf_res, sat_neg;
  logic [CW-1:0] cnt;
  fixed_divstep u_step (
    .r(r),
    .d_bit(d[N-1]),
    .b_mag(b_mag),
    .r_next(r_next),
    .q_bit(q_bit)
  );
  // Negative results may reach 2^(WIDTH-1) exactly; positive ones stop one short
  always_comb begin
    sat_neg = zero_b ? a_neg : sgn;
    ovf_res = !zero_b && (qm > (sgn ? N'(Q_MAX_NEG) : N'(Q_MAX_POS)));
    q_res = (zero_b || ovf_res) ? (sat_neg ? Q_MAX_NEG : Q_MAX_POS)
          : sgn ? ~qm[WIDTH-1:0] + WIDTH'(1) : qm[WIDTH-1:0];
  end
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      q <= '0;
      ovf <= 1'b0;
      dbz <= 1'b0;
      d <= '0;
      qm <= '0;
      r <= '0;
      b_mag <= '0;
      sgn <= 1'b0;
      a_neg <= 1'b0;
      zero_b <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sgn <= a[WIDTH-1] ^ b[WIDTH-1];
          a_neg <= a[WIDTH-1];
          zero_b <= b == '0;
          b_mag <= abs_mag(b);
          d <= {abs_mag(a), FRAC'(0)};
          r <= '0;
          qm <= '0;
          cnt <= '0;
          ovf <= 1'b0;
          dbz <= 1'b0;
          state <= (b == '0) ? DONE : CALC;
        end
        CALC: begin
          r <= r_next;
          d <= d << 1;
          qm <= {qm[N-2:0], q_bit};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= DONE;
        end
        DONE: if (!out_valid) begin
          out_valid <= 1'b1;
          q <= q_res;
          ovf <= ovf_res;
          dbz <= zero_b;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
